aes_dec_ingress: RTL and testbench
==================================

Name: aes_dec_ingress

Overview:
- Upstream feeder and downstream collector for the iterative inverse-AES core (`inv_aes`).
- Assembles 32-bit ciphertext words into 128-bit blocks and holds the decryption key.
- Issues one-cycle start pulses to the core only when it is free, tracks core busy with a timeout, and presents plaintext on a valid/ready output.
- The inverse core has no busy output, so this block owns all flow control around it.

Parameters:
- TIMEOUT, 16, max cycles in BUSY waiting for core_res_valid_in before abort (nominal core latency is 11).
- TCNT_W, 5, width of timeout counter; must satisfy 2^TCNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- s_valid  in  1  ciphertext word valid
- s_ready  out  1  ciphertext word accepted when s_valid & s_ready
- s_data  in  32  ciphertext word; first word of block = bits [127:96]
- key_load  in  1  load key_data (and iv_data) into holding registers
- key_data  in  128  original (round-0) decryption key
- iv_data  in  128  CBC IV; ignored unless AES_CBC_EN
- key_ready  out  1  high when key_load will be accepted
- core_valid_out  out  1  start pulse to core data_valid_in
- core_data_out  out  128  assembled ciphertext block to core data_in
- core_key_out  out  128  held key to core key_in
- core_res_valid_in  in  1  core res_valid_out
- core_res_in  in  128  core res_dec_out
- m_valid  out  1  plaintext valid
- m_ready  in  1  downstream accepts plaintext
- m_data  out  128  plaintext block
- err_timeout  out  1  sticky: core result missed deadline

Behaviour:
- Reset (resetn low at posedge):
  - word count = 0, block_full = 0, state = IDLE.
  - s_ready = 1, m_valid = 0, m_data = 0, core_valid_out = 0, err_timeout = 0.
  - key register = 0, timeout counter = 0.
- Reset mid-operation aborts everything; a late core result arriving after reset is ignored.
- Assembler:
  - s_ready = !block_full.
  - Each accepted word shifts into the block (word0 → [127:96] … word3 → [31:0]); count wraps 3→0.
  - On the 4th word, block_full is set at that edge.
- Start condition: block_full & state==IDLE & !m_valid.
  - core_valid_out is combinational on this condition, high exactly one cycle.
  - core_data_out = assembled block; core_key_out = key register (stable throughout).
  - At that edge: block_full clears, state → BUSY, timeout counter clears.
- The next block may fill while BUSY; s_ready stalls only once block_full is set again.
- BUSY state:
  - Counter increments each cycle.
  - core_res_valid_in → capture result into m_data, set m_valid, state → IDLE.
  - Counter reaches TIMEOUT without a result → err_timeout set (sticky until reset), block dropped, state → IDLE.
- core_res_valid_in while IDLE is ignored.
- Output: m_valid holds with m_data stable until m_valid & m_ready, then clears that edge. Set and clear cannot collide, because a start requires !m_valid.
- Key:
  - key_ready = (state==IDLE) & !core_valid_out.
  - key_load while !key_ready is ignored (not queued).
- Latency: 4th word accepted at edge t → core_valid_out high in cycle t+1 → core_res_valid_in at cycle t+12 → m_valid high from cycle t+13.
- Throughput: one block per 13 cycles with m_ready held high.

Optional Feature:
- Macro: AES_CBC_EN.
- Defined (CBC mode):
  - key_load also loads a chain register from iv_data.
  - At start, the issued ciphertext is saved in an in-flight register.
  - On result: m_data = core_res_in ^ chain, and chain ← in-flight ciphertext.
  - A timeout leaves chain unchanged.
  - Reset clears chain and the in-flight register to 0.
- Undefined (ECB mode): m_data = core_res_in; iv_data unused; no chain registers are instantiated.

Test Plan:
- ECB, FIPS-197 C.1: key_load key 000102030405060708090a0b0c0d0e0f; words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a with m_ready=1 → m_valid at t+13 with m_data 00112233445566778899aabbccddeeff, exactly one start pulse.
- Backpressure: same ECB vector twice, m_ready=0 → second block fills (s_ready low after its 4th word); no second start while m_valid; raising m_ready → second start the cycle after the first handshake, and the second result is identical.
- Timeout: core model never returns → err_timeout rises TIMEOUT=16 cycles after start; state returns to IDLE; a subsequent late core_res_valid_in produces no m_valid.
- Key gating: key_load during BUSY with a different key → ignored, core_key_out unchanged; the same key_load in IDLE → accepted.
- Reset mid-BUSY (resetn low for 1 cycle at start+5) → all outputs at reset values; core result at start+11 is ignored; the next full block decrypts correctly.
- AES_CBC_EN, SP800-38A F.2.2: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f:
  - ciphertext 7649abac8119b246cee98e9b12e9197d → 6bc1bee22e409f96e93d7e117393172a
  - then ciphertext 5086cb9b507219ee95db113a917678b2 → ae2d8a571e03ac9c9eb76fac45af8e51

Source files
------------

// File: rtl/aes_dec_ingress.sv
// Block assembler, key holder and flow control wrapped around the inverse-AES core.
// Define AES_CBC_EN to add CBC chaining (IV load, in-flight ciphertext, result XOR).
module aes_dec_ingress #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TCNT_W  = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         key_load,
    input  logic [127:0] key_data,
    input  logic [127:0] iv_data,
    output logic         key_ready,
    output logic         core_valid_out,
    output logic [127:0] core_data_out,
    output logic [127:0] core_key_out,
    input  logic         core_res_valid_in,
    input  logic [127:0] core_res_in,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         err_timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    logic [0:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              full_q, full_d;
    logic [127:0]      blk_q, blk_d;
    logic [127:0]      key_q, key_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              m_valid_q, m_valid_d;
    logic [127:0]      m_data_q, m_data_d;
    logic              err_q, err_d;
`ifdef AES_CBC_EN
    logic [127:0]      chain_q, chain_d;
    logic [127:0]      inflight_q, inflight_d;
`else
    logic              unused_iv;
    assign unused_iv = ^iv_data;
`endif

    logic s_accept;
    logic start;
    logic key_ok;

    assign s_accept = s_valid & ~full_q;
    // The core has no busy flag: start only when idle and the output slot is empty.
    assign start    = full_q & (state_q == ST_IDLE) & ~m_valid_q;
    assign key_ok   = (state_q == ST_IDLE) & ~start;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        full_d    = full_q;
        blk_d     = blk_q;
        key_d     = key_q;
        tcnt_d    = tcnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        err_d     = err_q;
`ifdef AES_CBC_EN
        chain_d    = chain_q;
        inflight_d = inflight_q;
`endif

        if (s_accept) begin
            blk_d = {blk_q[95:0], s_data};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                full_d = 1'b1;
            end
        end

        if (key_load && key_ok) begin
            key_d = key_data;
`ifdef AES_CBC_EN
            chain_d = iv_data;
`endif
        end

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (start) begin
            full_d  = 1'b0;
            state_d = ST_BUSY;
            tcnt_d  = '0;
`ifdef AES_CBC_EN
            inflight_d = blk_q;
`endif
        end

        if (state_q == ST_BUSY) begin
            if (core_res_valid_in) begin
`ifdef AES_CBC_EN
                m_data_d = core_res_in ^ chain_q;
                chain_d  = inflight_q;
`else
                m_data_d = core_res_in;
`endif
                m_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end else if (tcnt_q == TCNT_LAST) begin
                // Drop the block; the chain is left as it was.
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                tcnt_d = tcnt_q + TCNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            full_q    <= 1'b0;
            blk_q     <= '0;
            key_q     <= '0;
            tcnt_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
`ifdef AES_CBC_EN
            chain_q    <= '0;
            inflight_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            blk_q     <= blk_d;
            key_q     <= key_d;
            tcnt_q    <= tcnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
`ifdef AES_CBC_EN
            chain_q    <= chain_d;
            inflight_q <= inflight_d;
`endif
        end
    end

    assign s_ready        = ~full_q;
    assign key_ready      = key_ok;
    assign core_valid_out = start;
    assign core_data_out  = blk_q;
    assign core_key_out   = key_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_aes_dec_ingress.sv
// Randomized self-checking bench for aes_dec_ingress with a stand-in inverse core
// that answers 11 cycles after each start pulse; AES_CBC_EN selects the CBC checks.
module tb_aes_dec_ingress;

    localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_SP   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_SP  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1    = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] PT1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT2    = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] PT2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    // Raw block decryptions (before the CBC XOR) of CT1 / CT2 under K_SP.
    localparam logic [127:0] RAW1   = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] RAW2   = 128'hd86421fb9f1a1eda505ee1375746972c;

    logic         clk = 1'b0;
    logic         resetn;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         key_load;
    logic [127:0] key_data;
    logic [127:0] iv_data;
    logic         key_ready;
    logic         core_valid_out;
    logic [127:0] core_data_out;
    logic [127:0] core_key_out;
    logic         core_res_valid_in;
    logic [127:0] core_res_in;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         err_timeout;

    logic         mdl_rv, man_rv, core_mute;
    logic [127:0] mdl_res, man_res;
    logic         rnd_mode, rnd_ready, dir_ready;

    int           n_checks = 0;
    int           n_errors = 0;
    int           pulse_cnt = 0;
    logic [127:0] sb[$];
    logic [127:0] mdl_key, mdl_chain;

    assign core_res_valid_in = mdl_rv | man_rv;
    assign core_res_in       = mdl_rv ? mdl_res : man_res;
    assign m_ready           = rnd_mode ? rnd_ready : dir_ready;

    always #5 clk = ~clk;

    aes_dec_ingress dut (
        .clk               (clk),
        .resetn            (resetn),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .key_load          (key_load),
        .key_data          (key_data),
        .iv_data           (iv_data),
        .key_ready         (key_ready),
        .core_valid_out    (core_valid_out),
        .core_data_out     (core_data_out),
        .core_key_out      (core_key_out),
        .core_res_valid_in (core_res_valid_in),
        .core_res_in       (core_res_in),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .err_timeout       (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stand-in for the inverse core: known vectors, otherwise an arbitrary keyed permutation.
    function automatic logic [127:0] core_fn(input logic [127:0] ct, input logic [127:0] k);
        if (k == K_FIPS && ct == C_FIPS) return P_FIPS;
        if (k == K_SP && ct == CT1) return RAW1;
        if (k == K_SP && ct == CT2) return RAW2;
        return {ct[63:0], ct[127:64]} ^ k ^ 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_expect(input logic [127:0] ct);
`ifdef AES_CBC_EN
        sb.push_back(core_fn(ct, mdl_key) ^ mdl_chain);
        mdl_chain = ct;
`else
        sb.push_back(core_fn(ct, mdl_key));
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_key(input logic [127:0] k, input logic [127:0] iv, input logic acc);
        check_eq("key_ready", 128'(key_ready), 128'(acc));
        key_load = 1'b1;
        key_data = k;
        iv_data  = iv;
        tick(1);
        key_load = 1'b0;
        if (acc) begin
            mdl_key   = k;
            mdl_chain = iv;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int k = 0; k < 400 && !done; k++) begin
            done = s_ready;
            tick(1);
        end
        s_valid = 1'b0;
        check_eq("s_accept", 128'(done), 128'(1));
    endtask

    task automatic send_block(input logic [127:0] ct);
        for (int i = 0; i < 4; i++) send_word(ct[127-32*i -: 32]);
    endtask

    task automatic wait_mvalid(input int lim);
        for (int k = 0; k < lim && !m_valid; k++) tick(1);
        check_eq("wait_mvalid", 128'(m_valid), 128'(1));
    endtask

    task automatic check_reset_state();
        check_eq("rst_s_ready", 128'(s_ready), 128'(1));
        check_eq("rst_m_valid", 128'(m_valid), 128'(0));
        check_eq("rst_m_data", m_data, 128'(0));
        check_eq("rst_core_valid", 128'(core_valid_out), 128'(0));
        check_eq("rst_err", 128'(err_timeout), 128'(0));
        check_eq("rst_key", core_key_out, 128'(0));
        check_eq("rst_key_ready", 128'(key_ready), 128'(1));
    endtask

    // Core model: one result 11 cycles after each start pulse unless muted.
    initial begin
        int cd;
        logic [127:0] pend;
        cd = -1;
        pend = '0;
        mdl_rv = 1'b0;
        mdl_res = '0;
        forever begin
            @(negedge clk);
            mdl_rv = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mdl_rv  = 1'b1;
                    mdl_res = pend;
                    cd      = -1;
                end
            end
            if (core_valid_out) begin
                pend = core_fn(core_data_out, core_key_out);
                cd   = core_mute ? -1 : 11;
            end
        end
    end

    initial begin
        rnd_ready = 1'b0;
        forever begin
            @(negedge clk);
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: scoreboard on each handshake, stability while stalled.
    initial begin
        logic hold;
        logic [127:0] prev;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (core_valid_out) pulse_cnt++;
            if (hold) begin
                check_eq("m_valid_hold", 128'(m_valid), 128'(1));
                check_eq("m_data_hold", m_data, prev);
            end
            if (m_valid && m_ready) begin
                check_eq("sb_nonempty", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) check_eq("m_data", m_data, sb.pop_front());
            end
            hold = m_valid && !m_ready && resetn;
            prev = m_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        logic [127:0] ct, k1, k2;
        resetn = 1'b0; s_valid = 1'b0; s_data = '0; key_load = 1'b0;
        key_data = '0; iv_data = '0; man_rv = 1'b0; man_res = '0; core_mute = 1'b0;
        rnd_mode = 1'b0; dir_ready = 1'b1; mdl_key = '0; mdl_chain = '0;
        tick(3);
        resetn = 1'b1;
        check_reset_state();

`ifndef AES_CBC_EN
        // FIPS-197 C.1 with exact latency.
        load_key(K_FIPS, '0, 1'b1);
        p0 = pulse_cnt;
        push_expect(C_FIPS);
        send_block(C_FIPS);
        check_eq("start_pulse", 128'(core_valid_out), 128'(1));
        check_eq("core_data", core_data_out, C_FIPS);
        check_eq("core_key", core_key_out, K_FIPS);
        check_eq("s_ready_full", 128'(s_ready), 128'(0));
        check_eq("key_ready_start", 128'(key_ready), 128'(0));
        tick(11);
        check_eq("m_valid_early", 128'(m_valid), 128'(0));
        tick(1);
        check_eq("m_valid_lat", 128'(m_valid), 128'(1));
        check_eq("m_data_fips", m_data, P_FIPS);
        tick(3);
        check_eq("one_pulse", 128'(pulse_cnt - p0), 128'(1));

        // Backpressure: second block waits for the first handshake.
        dir_ready = 1'b0;
        p0 = pulse_cnt;
        push_expect(C_FIPS);
        send_block(C_FIPS);
        push_expect(C_FIPS);
        send_block(C_FIPS);
        check_eq("s_ready_stall", 128'(s_ready), 128'(0));
        wait_mvalid(100);
        tick(5);
        check_eq("no_second_start", 128'(pulse_cnt - p0), 128'(1));
        check_eq("hold_no_start", 128'(core_valid_out), 128'(0));
        check_eq("s_ready_stall2", 128'(s_ready), 128'(0));
        dir_ready = 1'b1;
        tick(1);
        check_eq("second_start", 128'(core_valid_out), 128'(1));
        check_eq("m_valid_clr", 128'(m_valid), 128'(0));
        wait_mvalid(100);
        check_eq("m_data_second", m_data, P_FIPS);
        tick(2);
        check_eq("pulses_bp", 128'(pulse_cnt - p0), 128'(2));
`else
        // SP800-38A F.2.2 CBC decryption, two chained blocks.
        dir_ready = 1'b1;
        load_key(K_SP, IV_SP, 1'b1);
        push_expect(CT1);
        send_block(CT1);
        check_eq("cbc_core_data", core_data_out, CT1);
        wait_mvalid(100);
        check_eq("cbc_pt1", m_data, PT1);
        tick(1);
        push_expect(CT2);
        send_block(CT2);
        wait_mvalid(100);
        check_eq("cbc_pt2", m_data, PT2);
        tick(2);
`endif

        // Timeout: core never answers; a late result is ignored.
        dir_ready = 1'b1;
        core_mute = 1'b1;
        send_block(rand128());
        check_eq("to_start", 128'(core_valid_out), 128'(1));
        tick(16);
        check_eq("to_err_early", 128'(err_timeout), 128'(0));
        check_eq("to_busy", 128'(key_ready), 128'(0));
        tick(1);
        check_eq("to_err", 128'(err_timeout), 128'(1));
        check_eq("to_idle", 128'(key_ready), 128'(1));
        core_mute = 1'b0;
        man_res = rand128();
        man_rv = 1'b1;
        tick(1);
        man_rv = 1'b0;
        tick(3);
        check_eq("to_late_ignored", 128'(m_valid), 128'(0));
        check_eq("to_sticky", 128'(err_timeout), 128'(1));

        // Key gating.
        k1 = rand128();
        k2 = ~k1;
        load_key(k1, rand128(), 1'b1);
        ct = rand128();
        push_expect(ct);
        send_block(ct);
        tick(3);
        load_key(k2, rand128(), 1'b0);
        check_eq("key_held", core_key_out, k1);
        wait_mvalid(100);
        tick(1);
        load_key(k2, rand128(), 1'b1);
        check_eq("key_loaded", core_key_out, k2);

        // Reset five cycles into BUSY; the stale result must be ignored.
        send_block(rand128());
        tick(5);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        mdl_key = '0;
        mdl_chain = '0;
        check_reset_state();
        tick(6);
        check_eq("rst_stale_12", 128'(m_valid), 128'(0));
        tick(1);
        check_eq("rst_stale_13", 128'(m_valid), 128'(0));
        load_key(K_FIPS, IV_SP, 1'b1);
        push_expect(C_FIPS);
        send_block(C_FIPS);
        wait_mvalid(100);
        tick(2);

        // Random blocks with input gaps and random backpressure.
        rnd_mode = 1'b1;
        load_key(rand128(), rand128(), 1'b1);
        for (int b = 0; b < 40; b++) begin
            ct = rand128();
            push_expect(ct);
            for (int i = 0; i < 4; i++) begin
                tick($urandom_range(0, 2));
                send_word(ct[127-32*i -: 32]);
            end
        end
        for (int k = 0; k < 3000 && sb.size() != 0; k++) tick(1);
        check_eq("drain", 128'(sb.size()), 128'(0));
        check_eq("no_err", 128'(err_timeout), 128'(0));
        rnd_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
